sync_fifo_ctrl: RTL



---
 rtl/sync_fifo_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sync_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sync_fifo_ctrl
// Single-clock FIFO with an inferred dual-pointer RAM, registered status
// flags and level count. Two read flavours, selected by FWFT:
//   FWFT = 0 : standard mode, rd_data is loaded on an accepted read and
//              rd_valid pulses for one cycle.
//   FWFT = 1 : first-word-fall-through, an output stage register holds the
//              head word; rd_en pops it and rd_valid mirrors ~empty.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   flush                 synchronous clear of pointers, flags and count
//   wr_en, wr_data        write request and word
//   rd_en                 read request (FWFT: pop head)
//   rd_data, rd_valid     read word and its qualifier
//   full, afull           no free entry / count >= AFULL_LEVEL
//   empty, aempty         no readable word / count <= AEMPTY_LEVEL
//   count                 words held (FWFT: includes output stage)
//   overflow, underflow   sticky: write while full / read while empty
// ---------------------------------------------------------------------------
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_LEVEL  = 2**ADDR_WIDTH - 2,
  parameter int AEMPTY_LEVEL = 2,
  parameter int FWFT         = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  afull,
  output logic                  empty,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH    = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ZERO_C   = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] ONE_C    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic                  empty_q, empty_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  ostg_q, ostg_d;   // FWFT output stage holds a word

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ram_ne;
  logic                  load;

  // Handshake decode: accepts use the registered flags; flush blocks both.
  always_comb begin
    wr_acc = wr_en & ~full_q & ~flush;
    rd_acc = rd_en & ~empty_q & ~flush;
    // RAM holds a word when the full-width pointers differ.
    ram_ne = (rptr_q != wptr_q);
    if (FWFT != 0) begin
      // Refill the output stage when it is free or being popped. Only
      // words already in RAM before this edge qualify, which gives the
      // 2-cycle write-to-visible latency on an empty FIFO.
      load = (~ostg_q | rd_acc) & ram_ne & ~flush;
    end else begin
      load = rd_acc;
    end
  end

  // Next-state computation for pointers, count, data and flags.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    ostg_d    = ostg_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    if (flush) begin
      wptr_d  = ZERO_C;
      rptr_d  = ZERO_C;
      count_d = ZERO_C;
      ostg_d  = 1'b0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_acc) begin
        wptr_d = wptr_q + ONE_C;
      end else begin
        wptr_d = wptr_q;
      end
      if (load) begin
        rptr_d    = rptr_q + ONE_C;
        rd_data_d = mem_q[rptr_q[ADDR_WIDTH-1:0]];
      end else begin
        rptr_d    = rptr_q;
        rd_data_d = rd_data_q;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      if (FWFT != 0) begin
        ostg_d = load | (ostg_q & ~rd_acc);
      end else begin
        ostg_d = 1'b0;
      end
      ovf_d = ovf_q | (wr_en & full_q);
      udf_d = udf_q | (rd_en & empty_q);
    end
    // Flags follow the next count so they move on the same edge as count.
    full_d   = (count_d == DEPTH_C);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
    if (FWFT != 0) begin
      // Readable only once the output stage is loaded.
      empty_d    = ~ostg_d;
      rd_valid_d = ostg_d;
    end else begin
      empty_d    = (count_d == ZERO_C);
      rd_valid_d = rd_acc;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q     <= ZERO_C;
      rptr_q     <= ZERO_C;
      count_q    <= ZERO_C;
      rd_data_q  <= {DATA_WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      empty_q    <= 1'b1;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      ostg_q     <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      empty_q    <= empty_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      ostg_q     <= ostg_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem_q[wptr_q[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign full      = full_q;
  assign afull     = afull_q;
  assign empty     = empty_q;
  assign aempty    = aempty_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule
